xrq_dispatch_ctrl: RTL and testbench

Dispatch controller between the XOCC request queue (XRQ) and the NOU decode stage. It pops one XRQ entry at a time, presents it to the decoder as a registered read port, and holds it until every functional unit in the entry's unit-of-vector (UOV) mask has accepted it through a per-unit valid/ready handshake. It tracks partial acceptance across cycles. With all units ready it sustains one entry per cycle. It optionally times out units that never accept.

---
 rtl/xrq_dispatch_ctrl_pkg.sv | 26 ++
 rtl/xrq_dispatch_ctrl_timer.sv | 32 +++
 rtl/xrq_dispatch_ctrl.sv | 139 +++++++++++++
 tb/tb_xrq_dispatch_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrq_dispatch_ctrl_pkg.sv
// Shared NOU types and XRQ entry layout for the XRQ dispatch controller.
// Entry layout from LSB: valid, sid, cmd, then the UOV unit mask in the MSBs.
package nou_pkg;

  localparam int NOU_SID_WIDTH      = 4;
  localparam int NOU_XOCC_CMD_WIDTH = 6;
  localparam int NOU_UOV_SIZE       = 5;

  localparam int UNIT_IRR   = 0;
  localparam int UNIT_BRR   = 1;
  localparam int UNIT_PWRR  = 2;
  localparam int UNIT_SPIDR = 3;
  localparam int UNIT_SPRR  = 4;

  localparam int XRQ_VALID_LSB = 0;
  localparam int XRQ_SID_LSB   = XRQ_VALID_LSB + 1;
  localparam int XRQ_CMD_LSB   = XRQ_SID_LSB + NOU_SID_WIDTH;
  localparam int XRQ_UOV_LSB   = XRQ_CMD_LSB + NOU_XOCC_CMD_WIDTH;
  localparam int XRQ_ENTRY_W   = XRQ_UOV_LSB + NOU_UOV_SIZE;

  typedef enum logic {
    XRQ_DISP_IDLE  = 1'b0,
    XRQ_DISP_ISSUE = 1'b1
  } xrq_disp_state_e;

endpackage

// File: rtl/xrq_dispatch_ctrl_timer.sv
// Stall watchdog for the XRQ dispatcher; only built with NOU_XRQ_DISP_TIMEOUT_EN.
// o_expire fires on the stalled cycle in which the count would reach all-ones.
`ifdef NOU_XRQ_DISP_TIMEOUT_EN
module xrq_disp_timer #(
  parameter int TIMEOUT_W = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  logic [TIMEOUT_W-1:0] r_cnt;

  assign o_expire = i_inc & (r_cnt == {{(TIMEOUT_W-1){1'b1}}, 1'b0});

  // Stall counter: cleared by load/accept and by its own expiry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= {TIMEOUT_W{1'b0}};
    end else if (i_clr | o_expire) begin
      r_cnt <= {TIMEOUT_W{1'b0}};
    end else if (i_inc) begin
      r_cnt <= r_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule
`endif

// File: rtl/xrq_dispatch_ctrl.sv
// XRQ -> NOU decode dispatcher: holds one entry until every unit in its UOV mask accepts.
// Optional stall timeout is enabled by defining NOU_XRQ_DISP_TIMEOUT_EN.
module xrq_dispatch_ctrl
  import nou_pkg::*;
#(
  parameter int ENTRY_W   = XRQ_ENTRY_W,
  parameter int NUM_UNITS = NOU_UOV_SIZE,
  parameter int TIMEOUT_W = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     disp_en,
  input  logic                     xrq_empty,
  input  logic [ENTRY_W-1:0]       xrq_head,
  output logic                     xrq_pop,
  output logic                     rd_port_vld,
  output logic [ENTRY_W-1:0]       entry_out,
  input  logic [NUM_UNITS-1:0]     unit_rdy,
  output logic                     drop_pulse,
  output logic                     err_timeout,
  output logic [NOU_SID_WIDTH-1:0] err_sid,
  output logic [NUM_UNITS-1:0]     err_mask,
  output logic                     idle
);

  localparam int UOV_LSB = ENTRY_W - NUM_UNITS;

  xrq_disp_state_e      r_state;
  logic [NUM_UNITS-1:0] r_pending;
  logic [UOV_LSB-1:0]   r_body;
  logic                 r_drop;

  logic                 w_in_issue;
  logic                 w_head_ok;
  logic                 w_last_accept;
  logic                 w_expire;
  logic                 w_load;
  logic [NUM_UNITS-1:0] w_head_mask;
  logic [NUM_UNITS-1:0] w_pend_next;

  assign w_head_mask   = xrq_head[ENTRY_W-1:UOV_LSB];
  assign w_head_ok     = xrq_head[XRQ_VALID_LSB] & (|w_head_mask);
  assign w_in_issue    = (r_state == XRQ_DISP_ISSUE);
  assign w_pend_next   = r_pending & ~unit_rdy;
  assign w_last_accept = w_in_issue & (w_pend_next == {NUM_UNITS{1'b0}});
  // Reload on the final accept keeps a fully-ready stream at one entry per cycle.
  assign w_load        = disp_en & ~xrq_empty & (~w_in_issue | w_last_accept) & ~w_expire;

  assign xrq_pop     = w_load;
  assign rd_port_vld = w_in_issue;
  assign entry_out   = {r_pending, r_body};
  assign drop_pulse  = r_drop;
  assign idle        = (r_state == XRQ_DISP_IDLE) & (r_pending == {NUM_UNITS{1'b0}});

  // Dispatch FSM: load/drop the head, shrink the pending mask, retire on completion or timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= XRQ_DISP_IDLE;
      r_pending <= {NUM_UNITS{1'b0}};
      r_body    <= {UOV_LSB{1'b0}};
      r_drop    <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_load) begin
        if (w_head_ok) begin
          r_state   <= XRQ_DISP_ISSUE;
          r_pending <= w_head_mask;
          r_body    <= xrq_head[UOV_LSB-1:0];
        end else begin
          r_state   <= XRQ_DISP_IDLE;
          r_pending <= {NUM_UNITS{1'b0}};
          r_drop    <= 1'b1;
        end
      end else if (w_expire) begin
        r_state   <= XRQ_DISP_IDLE;
        r_pending <= {NUM_UNITS{1'b0}};
      end else if (w_in_issue) begin
        r_pending <= w_pend_next;
        if (w_pend_next == {NUM_UNITS{1'b0}}) begin
          r_state <= XRQ_DISP_IDLE;
        end else begin
          r_state <= XRQ_DISP_ISSUE;
        end
      end else begin
        r_state <= r_state;
      end
    end
  end

`ifdef NOU_XRQ_DISP_TIMEOUT_EN
  logic                     w_any_accept;
  logic                     r_err_timeout;
  logic [NOU_SID_WIDTH-1:0] r_err_sid;
  logic [NUM_UNITS-1:0]     r_err_mask;

  assign w_any_accept = w_in_issue & (|(r_pending & unit_rdy));

  xrq_disp_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .i_clr    (w_load | w_any_accept),
    .i_inc    (w_in_issue & ~w_any_accept),
    .o_expire (w_expire)
  );

  // Error report: pulse plus the sid and units that never accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_timeout <= 1'b0;
      r_err_sid     <= {NOU_SID_WIDTH{1'b0}};
      r_err_mask    <= {NUM_UNITS{1'b0}};
    end else begin
      r_err_timeout <= w_expire;
      if (w_expire) begin
        r_err_sid  <= r_body[XRQ_SID_LSB +: NOU_SID_WIDTH];
        r_err_mask <= r_pending;
      end else begin
        r_err_sid  <= r_err_sid;
        r_err_mask <= r_err_mask;
      end
    end
  end

  assign err_timeout = r_err_timeout;
  assign err_sid     = r_err_sid;
  assign err_mask    = r_err_mask;
`else
  logic w_unused_cfg;

  assign w_expire     = 1'b0;
  assign err_timeout  = 1'b0;
  assign err_sid      = {NOU_SID_WIDTH{1'b0}};
  assign err_mask     = {NUM_UNITS{1'b0}};
  assign w_unused_cfg = (TIMEOUT_W > 0);
`endif

endmodule

// File: tb/tb_xrq_dispatch_ctrl.sv
// Self-checking bench for xrq_dispatch_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model of the dispatcher.
`timescale 1ns/1ps
module tb_xrq_dispatch_ctrl;
  import nou_pkg::*;

  localparam int EW = XRQ_ENTRY_W;
  localparam int NU = NOU_UOV_SIZE;
  localparam int SW = NOU_SID_WIDTH;
  localparam int CW = NOU_XOCC_CMD_WIDTH;
`ifdef NOU_XRQ_DISP_TIMEOUT_EN
  localparam int TW    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TW    = 10;
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          disp_en;
  logic          xrq_empty;
  logic [EW-1:0] xrq_head;
  logic          xrq_pop;
  logic          rd_port_vld;
  logic [EW-1:0] entry_out;
  logic [NU-1:0] unit_rdy;
  logic          drop_pulse;
  logic          err_timeout;
  logic [SW-1:0] err_sid;
  logic [NU-1:0] err_mask;
  logic          idle;

  always #5 clk = ~clk;

  xrq_dispatch_ctrl #(
    .ENTRY_W   (EW),
    .NUM_UNITS (NU),
    .TIMEOUT_W (TW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .disp_en     (disp_en),
    .xrq_empty   (xrq_empty),
    .xrq_head    (xrq_head),
    .xrq_pop     (xrq_pop),
    .rd_port_vld (rd_port_vld),
    .entry_out   (entry_out),
    .unit_rdy    (unit_rdy),
    .drop_pulse  (drop_pulse),
    .err_timeout (err_timeout),
    .err_sid     (err_sid),
    .err_mask    (err_mask),
    .idle        (idle)
  );

  int n_checks;
  int n_errors;

  // XRQ contents (head at index 0) and the model of the held entry
  logic [EW-1:0] q[$];
  logic          m_busy, m_drop, m_err;
  logic [NU-1:0] m_pend, m_emask;
  logic [SW-1:0] m_sid, m_esid;
  logic [CW-1:0] m_cmd;
  int            m_stall;

  // last sampled DUT outputs, for the scenario tasks
  logic          o_pop, o_vld, o_drop, o_idle, o_err;
  logic [EW-1:0] o_entry;
  logic [SW-1:0] o_esid;
  logic [NU-1:0] o_emask;

  function automatic logic [EW-1:0] mk(input logic v, input logic [SW-1:0] s,
                                       input logic [CW-1:0] c, input logic [NU-1:0] m);
    return {m, c, s, v};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_drop = 1'b0; m_err = 1'b0;
    m_pend = '0; m_emask = '0; m_sid = '0; m_esid = '0; m_cmd = '0;
    m_stall = 0;
  endtask

  // One clock: present the head, check all outputs against the model, then advance it.
  task automatic cycle();
    logic          stalled, expire, last, exp_pop;
    logic [NU-1:0] acc;
    logic [EW-1:0] head;
    xrq_empty = (q.size() == 0);
    head = '0;
    if (q.size() != 0) head = q[0];
    xrq_head = head;
    #4;
    acc     = m_pend & unit_rdy;
    stalled = m_busy && (acc == '0);
    expire  = TO_EN && stalled && (m_stall == (1 << TW) - 2);
    last    = m_busy && ((m_pend & ~unit_rdy) == '0);
    exp_pop = disp_en && !xrq_empty && (!m_busy || last) && !expire;
    o_pop = xrq_pop; o_vld = rd_port_vld; o_entry = entry_out; o_drop = drop_pulse;
    o_idle = idle; o_err = err_timeout; o_esid = err_sid; o_emask = err_mask;
    n_checks++;
    if (o_pop !== exp_pop) begin
      n_errors++; $display("FAIL pop @%0t: got %b expected %b", $time, o_pop, exp_pop);
    end
    n_checks++;
    if (o_vld !== m_busy) begin
      n_errors++; $display("FAIL rd_port_vld @%0t: got %b expected %b", $time, o_vld, m_busy);
    end
    if (m_busy) begin
      n_checks++;
      if (o_entry !== {m_pend, m_cmd, m_sid, 1'b1}) begin
        n_errors++; $display("FAIL entry_out @%0t: got %h expected %h", $time, o_entry, {m_pend, m_cmd, m_sid, 1'b1});
      end
    end
    n_checks++;
    if (o_drop !== m_drop) begin
      n_errors++; $display("FAIL drop_pulse @%0t: got %b expected %b", $time, o_drop, m_drop);
    end
    n_checks++;
    if (o_idle !== !m_busy) begin
      n_errors++; $display("FAIL idle @%0t: got %b expected %b", $time, o_idle, !m_busy);
    end
    n_checks++;
    if (o_err !== m_err) begin
      n_errors++; $display("FAIL err_timeout @%0t: got %b expected %b", $time, o_err, m_err);
    end
    if (m_err) begin
      n_checks++;
      if (o_esid !== m_esid || o_emask !== m_emask) begin
        n_errors++; $display("FAIL err_info @%0t: got sid %h mask %b expected sid %h mask %b", $time, o_esid, o_emask, m_esid, m_emask);
      end
    end
    @(posedge clk);
    m_drop = 1'b0;
    m_err  = 1'b0;
    if (exp_pop) begin
      head = q.pop_front();
      if (head[0] && head[EW-1 -: NU] != '0) begin
        m_busy = 1'b1; m_pend = head[EW-1 -: NU]; m_sid = head[SW:1]; m_cmd = head[SW+CW:SW+1];
      end else begin
        m_busy = 1'b0; m_pend = '0; m_drop = 1'b1;
      end
      m_stall = 0;
    end else if (expire) begin
      m_err = 1'b1; m_esid = m_sid; m_emask = m_pend;
      m_busy = 1'b0; m_pend = '0; m_stall = 0;
    end else if (m_busy) begin
      m_pend  = m_pend & ~unit_rdy;
      m_stall = (acc != '0) ? 0 : m_stall + 1;
      if (m_pend == '0) m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #2;
    n_checks++;
    if (rd_port_vld !== 1'b0 || xrq_pop !== 1'b0 || drop_pulse !== 1'b0 || idle !== 1'b1) begin
      n_errors++; $display("FAIL reset_ctrl: got vld %b pop %b drop %b idle %b expected 0 0 0 1", rd_port_vld, xrq_pop, drop_pulse, idle);
    end
    n_checks++;
    if (entry_out !== '0 || err_timeout !== 1'b0 || err_sid !== '0 || err_mask !== '0) begin
      n_errors++; $display("FAIL reset_data: got entry %h err %b sid %h mask %b expected all 0", entry_out, err_timeout, err_sid, err_mask);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    logic [2:0] vld_seen;
    logic       pop0, idle2;
    pop0 = 1'b0; idle2 = 1'b0; vld_seen = '0;
    q.push_back(mk(1'b1, 4'd3, 6'd17, 5'b00011));
    disp_en = 1'b1; unit_rdy = 5'b11111;
    for (int c = 0; c < 3; c++) begin
      cycle();
      vld_seen[c] = o_vld;
      if (c == 0) pop0 = o_pop;
      if (c == 2) idle2 = o_idle;
    end
    n_checks++;
    if (pop0 !== 1'b1) begin n_errors++; $display("FAIL single_pop: got %b expected 1", pop0); end
    n_checks++;
    if (vld_seen !== 3'b010) begin n_errors++; $display("FAIL single_vld: got %b expected 010", vld_seen); end
    n_checks++;
    if (idle2 !== 1'b1) begin n_errors++; $display("FAIL single_idle: got %b expected 1", idle2); end
    disp_en = 1'b0;
  endtask

  task automatic test_partial();
    logic [29:0] rdy_seq;
    logic [19:0] masks;
    logic        vld5, idle5;
    rdy_seq = {5'b00000, 5'b10000, 5'b01101, 5'b01001, 5'b00011, 5'b00000};
    masks = '0; vld5 = 1'b1; idle5 = 1'b0;
    q.push_back(mk(1'b1, 4'd5, 6'd33, 5'b10110));
    disp_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      unit_rdy = rdy_seq[c*5 +: 5];
      cycle();
      if (c >= 1 && c <= 4) masks[(4-c)*5 +: 5] = o_entry[EW-1 -: NU];
      if (c == 5) begin vld5 = o_vld; idle5 = o_idle; end
    end
    n_checks++;
    if (masks !== {5'b10110, 5'b10100, 5'b10100, 5'b10000}) begin
      n_errors++; $display("FAIL partial_masks: got %b expected 10110_10100_10100_10000", masks);
    end
    n_checks++;
    if (vld5 !== 1'b0 || idle5 !== 1'b1) begin
      n_errors++; $display("FAIL partial_done: got vld %b idle %b expected 0 1", vld5, idle5);
    end
    disp_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  pops, vlds;
    logic [15:0] sids;
    pops = '0; vlds = '0; sids = '0;
    for (int i = 0; i < 4; i++)
      q.push_back(mk(1'b1, SW'(i + 1), CW'($urandom), NU'($urandom_range(1, 31))));
    disp_en = 1'b1; unit_rdy = 5'b11111;
    for (int c = 0; c < 6; c++) begin
      cycle();
      pops[c] = o_pop;
      vlds[c] = o_vld;
      if (c >= 1 && c <= 4) sids[(c-1)*4 +: 4] = o_entry[SW:1];
    end
    n_checks++;
    if (pops !== 6'b001111) begin n_errors++; $display("FAIL b2b_pops: got %b expected 001111", pops); end
    n_checks++;
    if (vlds !== 6'b011110) begin n_errors++; $display("FAIL b2b_vld: got %b expected 011110", vlds); end
    n_checks++;
    if (sids !== 16'h4321) begin n_errors++; $display("FAIL b2b_order: got %h expected 4321", sids); end
    disp_en = 1'b0;
  endtask

  task automatic test_drop();
    logic [3:0] pops, drops, vlds;
    pops = '0; drops = '0; vlds = '0;
    q.push_back(mk(1'b0, 4'd1, 6'd2, 5'b11111));
    q.push_back(mk(1'b1, 4'd2, 6'd3, 5'b00000));
    disp_en = 1'b1; unit_rdy = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      cycle();
      pops[c] = o_pop; drops[c] = o_drop; vlds[c] = o_vld;
    end
    n_checks++;
    if (pops !== 4'b0011) begin n_errors++; $display("FAIL drop_pops: got %b expected 0011", pops); end
    n_checks++;
    if (drops !== 4'b0110) begin n_errors++; $display("FAIL drop_pulses: got %b expected 0110", drops); end
    n_checks++;
    if (vlds !== 4'b0000) begin n_errors++; $display("FAIL drop_vld: got %b expected 0000", vlds); end
    disp_en = 1'b0;
  endtask

  task automatic test_timeout();
    int            err_cyc, n_pulse, pop2_cyc, n_pop;
    logic [SW-1:0] e_sid;
    logic [NU-1:0] e_mask;
    err_cyc = -1; n_pulse = 0; pop2_cyc = -1; n_pop = 0; e_sid = '0; e_mask = '0;
    q.push_back(mk(1'b1, 4'd9, 6'd5, 5'b01000));
    q.push_back(mk(1'b1, 4'd10, 6'd6, 5'b00001));
    disp_en = 1'b1;
    for (int c = 0; c < 23; c++) begin
      unit_rdy = (c < 20) ? 5'b00000 : 5'b11111;
      cycle();
      if (o_err) begin
        n_pulse++;
        if (err_cyc < 0) begin err_cyc = c; e_sid = o_esid; e_mask = o_emask; end
      end
      if (o_pop) begin
        n_pop++;
        if (n_pop == 2) pop2_cyc = c;
      end
    end
    n_checks++;
    if (n_pulse != (TO_EN ? 1 : 0) || err_cyc != (TO_EN ? 16 : -1)) begin
      n_errors++; $display("FAIL timeout_pulse: got %0d pulses at cycle %0d expected %0d at %0d", n_pulse, err_cyc, TO_EN ? 1 : 0, TO_EN ? 16 : -1);
    end
    n_checks++;
    if (e_mask !== (TO_EN ? 5'b01000 : 5'b00000) || e_sid !== (TO_EN ? 4'd9 : 4'd0)) begin
      n_errors++; $display("FAIL timeout_info: got sid %0d mask %b", e_sid, e_mask);
    end
    n_checks++;
    if (pop2_cyc != (TO_EN ? 16 : 20)) begin
      n_errors++; $display("FAIL timeout_reload: got cycle %0d expected %0d", pop2_cyc, TO_EN ? 16 : 20);
    end
    disp_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [NU-1:0] held_mask;
    logic          pop0;
    logic [EW-1:0] ent1;
    held_mask = '0; pop0 = 1'b0; ent1 = '0;
    q.push_back(mk(1'b1, 4'd6, 6'd7, 5'b00100));
    q.push_back(mk(1'b1, 4'd7, 6'd8, 5'b00010));
    disp_en = 1'b1; unit_rdy = 5'b00000;
    cycle();
    cycle();
    held_mask = o_entry[EW-1 -: NU];
    n_checks++;
    if (held_mask !== 5'b00100) begin n_errors++; $display("FAIL rmid_pre: got %b expected 00100", held_mask); end
    disp_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (rd_port_vld !== 1'b0 || idle !== 1'b1 || entry_out !== '0 || drop_pulse !== 1'b0) begin
      n_errors++; $display("FAIL rmid_reset: got vld %b idle %b entry %h drop %b expected 0 1 0 0", rd_port_vld, idle, entry_out, drop_pulse);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    disp_en = 1'b1; unit_rdy = 5'b11111;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (c == 0) pop0 = o_pop;
      if (c == 1) ent1 = o_entry;
    end
    n_checks++;
    if (pop0 !== 1'b1 || ent1 !== mk(1'b1, 4'd7, 6'd8, 5'b00010)) begin
      n_errors++; $display("FAIL rmid_reload: got pop %b entry %h expected 1 %h", pop0, ent1, mk(1'b1, 4'd7, 6'd8, 5'b00010));
    end
    disp_en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (q.size() < 6 && $urandom_range(0, 2) != 0)
        q.push_back(mk($urandom_range(0, 9) != 0, SW'($urandom), CW'($urandom),
                       ($urandom_range(0, 7) == 0) ? 5'b00000 : NU'($urandom)));
      disp_en  = ($urandom_range(0, 7) != 0);
      unit_rdy = (i < 300) ? NU'($urandom) : NU'($urandom & $urandom);
      cycle();
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rstn = 1'b1; disp_en = 1'b0; xrq_empty = 1'b1; xrq_head = '0; unit_rdy = '0;
    model_reset();
    test_reset();
    test_single();
    test_partial();
    test_back_to_back();
    test_drop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
